// File: rtl/simon_input_capture.sv
// Simon player-input stage: synchronises and debounces the colour buttons, records
// accepted presses and checks them against the expected sequence. Optional macro: INPUT_TIMEOUT_EN.
module simon_input_capture #(
    parameter int unsigned MAX_LEN         = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  btn,
    input  logic        start,
    input  logic [5:0]  seq_len,
    input  logic [63:0] exp_seq,
    output logic [3:0]  incolor,
    output logic [63:0] user_seq,
    output logic [31:0] user_pos,
    output logic        correct,
    output logic        score_update,
    output logic        busy,
    output logic        timeout
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned LEN_W = 6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_PRESS,
        S_DEBOUNCE,
        S_WAIT_RELEASE
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         btn_meta_q, btn_s_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         cand_q, cand_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [63:0]        exp_q, exp_d;
    logic               mismatch_q, mismatch_d;
    logic [3:0]         incolor_q, incolor_d;
    logic [63:0]        user_seq_q, user_seq_d;
    logic [31:0]        user_pos_q, user_pos_d;
    logic               correct_q, correct_d;
    logic               score_update_q, score_update_d;
    logic               busy_q, busy_d;
    logic               timeout_q, timeout_d;

    logic               btn_onehot_c;
    logic [1:0]         code_c;
    logic [LEN_W-1:0]   len_clamped_c;
    logic [5:0]         bit_idx_c;

`ifdef INPUT_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]   tmo_q, tmo_d;
`endif

    // Decode helpers: one-hot test, candidate encoding, length clamp, write index
    always_comb begin
        btn_onehot_c = (btn_s_q != 4'd0) && ((btn_s_q & (btn_s_q - 4'd1)) == 4'd0);
        unique case (cand_q)
            4'b0010: code_c = 2'd1;
            4'b0100: code_c = 2'd2;
            4'b1000: code_c = 2'd3;
            default: code_c = 2'd0;
        endcase
        if (seq_len == 6'd0) begin
            len_clamped_c = LEN_W'(1);
        end else if (32'(seq_len) > MAX_LEN) begin
            len_clamped_c = LEN_W'(MAX_LEN);
        end else begin
            len_clamped_c = seq_len;
        end
        bit_idx_c = {user_pos_q[4:0], 1'b0};
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        cand_d         = cand_q;
        len_d          = len_q;
        exp_d          = exp_q;
        mismatch_d     = mismatch_q;
        incolor_d      = incolor_q;
        user_seq_d     = user_seq_q;
        user_pos_d     = user_pos_q;
        correct_d      = correct_q;
        score_update_d = 1'b0;
        timeout_d      = timeout_q;
`ifdef INPUT_TIMEOUT_EN
        tmo_d          = '0;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    user_seq_d = '0;
                    user_pos_d = '0;
                    incolor_d  = '0;
                    correct_d  = 1'b0;
                    timeout_d  = 1'b0;
                    mismatch_d = 1'b0;
                    len_d      = len_clamped_c;
                    exp_d      = exp_seq;
                    state_d    = S_WAIT_PRESS;
                end
            end
            S_WAIT_PRESS: begin
                if (btn_onehot_c) begin
                    cand_d  = btn_s_q;
                    cnt_d   = CNT_W'(DEBOUNCE_CYCLES);
                    state_d = S_DEBOUNCE;
                end
`ifdef INPUT_TIMEOUT_EN
                else if (btn_s_q == 4'd0) begin
                    if (32'(tmo_q) == TIMEOUT_CYCLES - 1) begin
                        correct_d      = 1'b0;
                        timeout_d      = 1'b1;
                        score_update_d = 1'b1;
                        state_d        = S_IDLE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
`endif
            end
            S_DEBOUNCE: begin
                if (btn_s_q != cand_q) begin
                    state_d = S_WAIT_PRESS;
                end else if (cnt_q == CNT_W'(1)) begin
                    user_seq_d[bit_idx_c +: 2] = code_c;
                    incolor_d  = cand_q;
                    user_pos_d = user_pos_q + 32'd1;
                    mismatch_d = (code_c != exp_q[bit_idx_c +: 2]);
                    cnt_d      = CNT_W'(DEBOUNCE_CYCLES);
                    state_d    = S_WAIT_RELEASE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_WAIT_RELEASE: begin
                // Any held button restarts the release count
                if (btn_s_q != 4'd0) begin
                    cnt_d = CNT_W'(DEBOUNCE_CYCLES);
                end else if (cnt_q == CNT_W'(1)) begin
                    if (mismatch_q) begin
                        correct_d      = 1'b0;
                        score_update_d = 1'b1;
                        state_d        = S_IDLE;
                    end else if (user_pos_q == 32'(len_q)) begin
                        correct_d      = 1'b1;
                        score_update_d = 1'b1;
                        state_d        = S_IDLE;
                    end else begin
                        state_d = S_WAIT_PRESS;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            btn_meta_q     <= '0;
            btn_s_q        <= '0;
            cnt_q          <= '0;
            cand_q         <= '0;
            len_q          <= '0;
            exp_q          <= '0;
            mismatch_q     <= 1'b0;
            incolor_q      <= '0;
            user_seq_q     <= '0;
            user_pos_q     <= '0;
            correct_q      <= 1'b0;
            score_update_q <= 1'b0;
            busy_q         <= 1'b0;
            timeout_q      <= 1'b0;
`ifdef INPUT_TIMEOUT_EN
            tmo_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            btn_meta_q     <= btn;
            btn_s_q        <= btn_meta_q;
            cnt_q          <= cnt_d;
            cand_q         <= cand_d;
            len_q          <= len_d;
            exp_q          <= exp_d;
            mismatch_q     <= mismatch_d;
            incolor_q      <= incolor_d;
            user_seq_q     <= user_seq_d;
            user_pos_q     <= user_pos_d;
            correct_q      <= correct_d;
            score_update_q <= score_update_d;
            busy_q         <= busy_d;
            timeout_q      <= timeout_d;
`ifdef INPUT_TIMEOUT_EN
            tmo_q          <= tmo_d;
`endif
        end
    end

    assign incolor      = incolor_q;
    assign user_seq     = user_seq_q;
    assign user_pos     = user_pos_q;
    assign correct      = correct_q;
    assign score_update = score_update_q;
    assign busy         = busy_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_simon_input_capture.sv
// Bench for simon_input_capture: directed scenarios plus random rounds checked
// against a press-level model of the game rules.
module tb_simon_input_capture;

    localparam int unsigned MAX_LEN = 32;
    localparam int unsigned DEB     = 2;
    localparam int unsigned TMO     = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  btn = 4'd0;
    logic        start = 1'b0;
    logic [5:0]  seq_len = 6'd0;
    logic [63:0] exp_seq = 64'd0;
    logic [3:0]  incolor;
    logic [63:0] user_seq;
    logic [31:0] user_pos;
    logic        correct;
    logic        score_update;
    logic        busy;
    logic        timeout;

    int n_checks = 0;
    int n_errors = 0;
    int su_cnt   = 0;
    logic su_corr = 1'b0;
    int su0;

    // Model state
    int m_len;
    int m_exp[$];
    int m_got[$];
    bit m_done;
    bit m_ok;

    simon_input_capture #(
        .MAX_LEN(MAX_LEN),
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .btn(btn),
        .start(start),
        .seq_len(seq_len),
        .exp_seq(exp_seq),
        .incolor(incolor),
        .user_seq(user_seq),
        .user_pos(user_pos),
        .correct(correct),
        .score_update(score_update),
        .busy(busy),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (score_update === 1'b1) begin
                su_cnt++;
                su_corr = correct;
            end
        end
    endtask

    task automatic begin_round(input logic [5:0] len, input logic [63:0] e);
        seq_len = len;
        exp_seq = e;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    task automatic press(input int code, input int hold = 6, input int rel = 6);
        btn = 4'(1 << code);
        tick(hold);
        btn = 4'd0;
        tick(rel);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_incolor"}, 64'(incolor), 64'd0);
        chk({tag, "_user_seq"}, user_seq, 64'd0);
        chk({tag, "_user_pos"}, 64'(user_pos), 64'd0);
        chk({tag, "_correct"}, 64'(correct), 64'd0);
        chk({tag, "_score_update"}, 64'(score_update), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_timeout"}, 64'(timeout), 64'd0);
    endtask

    function automatic void m_start(input logic [5:0] len, input logic [63:0] e);
        if (len == 6'd0) m_len = 1;
        else if (int'(len) > int'(MAX_LEN)) m_len = int'(MAX_LEN);
        else m_len = int'(len);
        m_exp.delete();
        m_got.delete();
        for (int k = 0; k < 32; k++) m_exp.push_back(int'(e[2*k +: 2]));
        m_done = 1'b0;
        m_ok   = 1'b0;
    endfunction

    function automatic void m_press(input int code);
        int idx;
        if (m_done) return;
        idx = m_got.size();
        m_got.push_back(code);
        if (code != m_exp[idx]) begin
            m_done = 1'b1;
            m_ok   = 1'b0;
        end else if (m_got.size() == m_len) begin
            m_done = 1'b1;
            m_ok   = 1'b1;
        end
    endfunction

    function automatic logic [63:0] m_useq();
        logic [63:0] v = 64'd0;
        foreach (m_got[k]) v = v | (64'(m_got[k]) << (2 * k));
        return v;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        tick(2);
        chk_all_zero("reset");
        rst = 1'b0;
        tick();

        // Full match with exact press latency and result timing
        begin_round(6'd3, 64'h24);
        chk("fm_busy", 64'(busy), 64'd1);
        btn = 4'b0001;
        tick(4);
        chk("fm_lat_before", 64'(user_pos), 64'd0);
        tick(1);
        chk("fm_lat_pos1", 64'(user_pos), 64'd1);
        chk("fm_lat_incolor", 64'(incolor), 64'b0001);
        tick(1);
        btn = 4'd0;
        tick(6);
        press(1);
        chk("fm_pos2", 64'(user_pos), 64'd2);
        btn = 4'b0100;
        tick(6);
        btn = 4'd0;
        su0 = su_cnt;
        tick(3);
        chk("fm_no_early_su", 64'(su_cnt - su0), 64'd0);
        tick(1);
        chk("fm_su", 64'(score_update), 64'd1);
        chk("fm_correct", 64'(correct), 64'd1);
        chk("fm_busy_fall", 64'(busy), 64'd0);
        chk("fm_pos3", 64'(user_pos), 64'd3);
        chk("fm_user_seq", user_seq, 64'h24);

        // Back-to-back start, used as the mismatch round
        seq_len = 6'd4;
        exp_seq = 64'h3;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        chk("b2b_su_once", 64'(su_cnt - su0), 64'd1);
        chk("b2b_busy", 64'(busy), 64'd1);
        chk("b2b_pos_clr", 64'(user_pos), 64'd0);
        chk("b2b_correct_clr", 64'(correct), 64'd0);
        su0 = su_cnt;
        press(2);
        chk("mm_user_seq", user_seq, 64'd2);
        chk("mm_pos", 64'(user_pos), 64'd1);
        chk("mm_su", 64'(su_cnt - su0), 64'd1);
        chk("mm_correct", 64'(su_corr), 64'd0);
        chk("mm_idle", 64'(busy), 64'd0);

        // Bounce rejection, multi-hot, ignored start, zero-length clamp
        tick(2);
        begin_round(6'd0, 64'd0);
        repeat (5) begin
            btn = 4'b0001;
            tick();
            btn = 4'd0;
            tick();
        end
        tick(4);
        chk("bounce_pos", 64'(user_pos), 64'd0);
        chk("bounce_seq", user_seq, 64'd0);
        chk("bounce_busy", 64'(busy), 64'd1);
        btn = 4'b0011;
        tick(10);
        btn = 4'd0;
        tick(4);
        chk("multi_pos", 64'(user_pos), 64'd0);
        chk("multi_busy", 64'(busy), 64'd1);
        seq_len = 6'd5;
        exp_seq = '1;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        su0 = su_cnt;
        press(0);
        chk("clamp_pos", 64'(user_pos), 64'd1);
        chk("clamp_su", 64'(su_cnt - su0), 64'd1);
        chk("clamp_correct", 64'(su_corr), 64'd1);
        chk("clamp_idle", 64'(busy), 64'd0);

        // Reset mid-round, then a clean round
        tick(2);
        begin_round(6'd5, 64'h1E4);
        press(0);
        press(1);
        chk("rmr_pos2", 64'(user_pos), 64'd2);
        su0 = su_cnt;
        rst = 1'b1;
        tick();
        chk_all_zero("rmr");
        chk("rmr_no_su", 64'(su_cnt - su0), 64'd0);
        rst = 1'b0;
        tick();
        begin_round(6'd1, 64'h1);
        press(1);
        chk("rmr_new_seq", user_seq, 64'd1);
        chk("rmr_new_pos", 64'(user_pos), 64'd1);
        chk("rmr_new_su", 64'(su_cnt - su0), 64'd1);
        chk("rmr_new_correct", 64'(su_corr), 64'd1);

        // Idle timeout behaviour
        tick(2);
`ifdef INPUT_TIMEOUT_EN
        su0 = su_cnt;
        begin_round(6'd2, 64'd0);
        tick(TMO + 5);
        chk("tmo_flag", 64'(timeout), 64'd1);
        chk("tmo_correct", 64'(correct), 64'd0);
        chk("tmo_su", 64'(su_cnt - su0), 64'd1);
        chk("tmo_idle", 64'(busy), 64'd0);
        begin_round(6'd1, 64'd0);
        chk("tmo_clr", 64'(timeout), 64'd0);
        press(0);
`else
        begin_round(6'd2, 64'd0);
        tick(100);
        chk("notmo_busy", 64'(busy), 64'd1);
        chk("notmo_flag", 64'(timeout), 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
`endif

        // Random rounds against the model
        for (int r = 0; r < 10; r++) begin
            logic [5:0]  len;
            logic [63:0] e;
            int          code;
            int          guard;
            tick(2);
            len = 6'($urandom_range(0, 40));
            e   = {$urandom, $urandom};
            m_start(len, e);
            su0 = su_cnt;
            begin_round(len, e);
            guard = 0;
            while (!m_done && guard < 40) begin
                if ($urandom_range(0, 7) == 0) code = int'($urandom_range(0, 3));
                else code = m_exp[m_got.size()];
                m_press(code);
                press(code);
                chk("rnd_pos", 64'(user_pos), 64'(m_got.size()));
                chk("rnd_seq", user_seq, m_useq());
                chk("rnd_incolor", 64'(incolor), 64'(1 << code));
                chk("rnd_busy", 64'(busy), 64'(!m_done));
                guard++;
            end
            chk("rnd_su", 64'(su_cnt - su0), 64'd1);
            chk("rnd_correct", 64'(su_corr), 64'(m_ok));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/simon_input_capture.md
# simon_input_capture

Player-input stage of the Simon Game: debounces the four colour buttons, encodes each accepted press, packs it into the user sequence and checks it on the fly against the expected sequence from the game controller. Sits on the consumer side of `controls_if`. Drives `incolor`, `user_seq`, `user_pos` and `score_update` toward the controller and score manager, and receives `start`, `seq_len` and the expected sequence back.

## Interface

**Parameters**

- `MAX_LEN`, default 32: maximum sequence length in colours.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles required to accept a press or a release (≥1).
- `TIMEOUT_CYCLES`, default 1000: idle-press limit; used only with `INPUT_TIMEOUT_EN`.

**Ports** (one clock; reset is synchronous and active-high)

- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `btn` input 4: raw buttons, one-hot [0:Green, 1:Yellow, 2:Red, 3:Blue]. Asynchronous.
- `start` input 1: round-start pulse from the controller.
- `seq_len` input 6: colours expected this round (1–MAX_LEN).
- `exp_seq` input 64: expected sequence; colour k is at [2k+1:2k].
- `incolor` output 4: one-hot copy of the last accepted colour.
- `user_seq` output 64: packed user sequence, same layout as `exp_seq`.
- `user_pos` output 32: number of colours accepted this round.
- `correct` output 1: round result (1 = full match).
- `score_update` output 1: one-cycle pulse when the round ends.
- `busy` output 1: high in every state except IDLE.
- `timeout` output 1: round ended by timeout.

## Operation

**Synchroniser.** `btn` passes through a 2-flop synchroniser to produce `btn_s`. All logic uses `btn_s`.

**Colour encoding.** Green=0, Yellow=1, Red=2, Blue=3.

**States.** IDLE, WAIT_PRESS, DEBOUNCE, WAIT_RELEASE.

- **IDLE**
  - `start`=1 clears `user_seq`, `user_pos`, `incolor`, `correct` and `timeout`.
  - Latches `exp_seq` and the length, then goes to WAIT_PRESS.
  - Length rule: `seq_len`=0 is latched as 1; `seq_len`>MAX_LEN is latched as MAX_LEN.
- **WAIT_PRESS**
  - `btn_s` one-hot: load the debounce counter and capture the candidate colour, then go to DEBOUNCE.
  - `btn_s`=0 or multi-hot: stay.
- **DEBOUNCE**
  - Counter decrements while `btn_s` equals the candidate.
  - Any change in `btn_s` returns to WAIT_PRESS with no write.
  - At the DEBOUNCE_CYCLES-th stable cycle the press is accepted:
    - `user_seq[2p+1:2p]` ← code, where p is the current `user_pos`.
    - `incolor` ← candidate; `user_pos` ← p+1.
    - Internal `mismatch` ← (code ≠ `exp_seq[2p+1:2p]`).
    - Next state is WAIT_RELEASE.
- **WAIT_RELEASE**
  - Waits for `btn_s`=0 for DEBOUNCE_CYCLES consecutive cycles; a nonzero value restarts the count.
  - On release:
    - If `mismatch`: `correct`←0, `score_update` pulses, go to IDLE.
    - Else if `user_pos` = latched length: `correct`←1, `score_update` pulses, go to IDLE.
    - Otherwise go to WAIT_PRESS.

**Other rules.**
- `start` while `busy` is ignored.
- `user_seq` bits at and above position `user_pos` stay 0.
- `user_pos` never exceeds the latched length, so no wrap-around occurs.

## Timing

- **Reset.** All outputs are 0 and the state is IDLE. A reset mid-round aborts the round on the next edge with no `score_update` pulse.
- **Press latency.** Edge 1 is the first edge at which `btn` is sampled one-hot. `incolor`, `user_seq` and `user_pos` update at edge 3+DEBOUNCE_CYCLES:
  - 2 synchroniser edges;
  - 1 edge for WAIT_PRESS→DEBOUNCE;
  - DEBOUNCE_CYCLES counting edges.
- **Result timing.** `correct` and `score_update` update on the same edge that completes the release count. `score_update` is high for exactly one cycle, and `busy` falls on that same edge.
- **Back-to-back start.** `start` in the cycle right after `score_update` is accepted.
- **Simultaneous events.** A multi-hot press during DEBOUNCE aborts the candidate. A press during WAIT_RELEASE is not recorded until a full release has been seen.

## Configuration

- **`INPUT_TIMEOUT_EN` defined.** A counter runs while in WAIT_PRESS.
  - It clears on entry to WAIT_PRESS and whenever `btn_s`≠0.
  - On reaching TIMEOUT_CYCLES it forces `correct`←0 and `timeout`←1, pulses `score_update`, and goes to IDLE.
  - `timeout` holds until the next accepted `start` or `rst`.
- **`INPUT_TIMEOUT_EN` undefined.** There is no timeout counter, `timeout` is tied to 0, `TIMEOUT_CYCLES` is unused, and WAIT_PRESS waits indefinitely.

## Test plan

Bench uses DEBOUNCE_CYCLES=2 and TIMEOUT_CYCLES=20.

- **Full match.** `start`, `seq_len`=3, `exp_seq`=…_10_01_00; press Green, Yellow, Red, each held 6 cycles and released 6 cycles.
  - Required: `user_pos` goes 1, 2, 3; `user_seq[5:0]`=6'b100100; one `score_update` pulse with `correct`=1.
- **Mismatch.** `seq_len`=4, expected colour 0 = Blue; press Red.
  - Required: `user_seq[1:0]`=2; after release, `score_update` pulses with `correct`=0, `user_pos`=1, state IDLE.
- **Bounce rejection.** `btn`=4'b0001 for 1 cycle, then 0, repeated 5 times.
  - Required: no write, `user_pos`=0, `busy`=1.
- **Multi-hot and clamping.** `btn`=4'b0011 held 10 cycles.
  - Required: ignored.
  - Then `seq_len`=0: the round ends after one correct press with `correct`=1.
- **Reset mid-round.** `rst` after 2 accepted presses.
  - Required: all outputs 0 on the next edge, no `score_update`, and a subsequent `start` begins a clean round.
- **Timeout (`INPUT_TIMEOUT_EN`).** No press for 20 cycles after `start`.
  - Required: `timeout`=1, `correct`=0, one `score_update` pulse.
  - Without the macro: `busy` is still 1 after 100 cycles.
